bw_hpt_walker: RTL and testbench

//  Hash page-table walker feeding the TLB: on a TLB miss, hashes VA+ASID to a page-table-group (PTG)

---
 rtl/bw_hpt_walker.sv | 246 ++++++++++++++++++++++++
 tb/tb_bw_hpt_walker.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bw_hpt_walker.sv
// Hash page-table walker: hashes VA+ASID to a PTG bucket, scans its 8 HPTEs, linear-probes on miss.
// Optional accessed-bit write-back is compiled in with BW_HPTW_ABIT_UPDATE_EN.
module bw_hpt_walker #(
  parameter int AWID      = 64,
  parameter int HBITS     = 10,
  parameter int MAX_PROBE = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  output logic            req_rdy_o,
  input  logic [AWID-1:0] vadr_i,
  input  logic [9:0]      asid_i,
  input  logic [AWID-1:0] ptbr_i,
  output logic            resp_v_o,
  output logic            resp_hit_o,
  output logic            resp_err_o,
  output logic [127:0]    resp_pte_o,
  output logic [2:0]      resp_idx_o,
  output logic            mem_cyc_o,
  output logic            mem_we_o,
  output logic [AWID-1:0] mem_adr_o,
  output logic [127:0]    mem_dat_o,
  input  logic            mem_ack_i,
  input  logic            mem_err_i,
  input  logic [127:0]    mem_dat_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EVAL, S_ABITWR, S_DONE, S_FAULT
  } state_t;

  localparam logic [3:0] LAST_PROBE = 4'(MAX_PROBE - 1);

  state_t state_q, state_d;

  // Only VA[61:14] takes part in the match; the rest is not stored.
  logic [47:0]      va_q, va_d;
  logic [9:0]       asid_q, asid_d;
  logic [AWID-1:0]  ptbr_q, ptbr_d;
  logic [HBITS-1:0] h_q, h_d;
  logic [3:0]       n_q, n_d;
  logic [2:0]       k_q, k_d;

  logic             mhit_q, mhit_d;
  logic [2:0]       midx_q, midx_d;
  logic [127:0]     mpte_q, mpte_d;

  logic             rhit_q, rhit_d;
  logic             rerr_q, rerr_d;
  logic [127:0]     rpte_q, rpte_d;
  logic [2:0]       ridx_q, ridx_d;

  logic             beat_hit;
  logic [AWID-1:0]  bucket_adr;
  logic [2:0]       beat_sel;
  logic             bus_act;

  logic unused_vadr;
  assign unused_vadr = ^{vadr_i[AWID-1:62], vadr_i[13:0]};

  function automatic logic pte_match(input logic [127:0] p, input logic [47:0] va,
                                     input logic [9:0] as);
    return p[31] && (p[47:32] == va[15:0]) && (p[127:96] == va[47:16]) &&
           (p[53] || (p[63:54] == as));
  endfunction

  assign beat_hit   = pte_match(mem_dat_i, va_q, asid_q);
  assign bucket_adr = ptbr_q + AWID'({h_q, 7'b0});

`ifdef BW_HPTW_ABIT_UPDATE_EN
  // wph_q=0: one setup cycle before the write beat goes on the bus.
  logic         wph_q, wph_d;
  logic [127:0] mpte_aset;
  logic         wr_beat;

  assign mpte_aset = {mpte_q[127:18], 1'b1, mpte_q[16:0]};
  assign wr_beat   = (state_q == S_ABITWR) && wph_q;
  assign beat_sel  = (state_q == S_ABITWR) ? midx_q : k_q;
  assign bus_act   = (state_q == S_FETCH) || wr_beat;
  assign mem_we_o  = wr_beat;
  assign mem_dat_o = wr_beat ? mpte_aset : '0;
`else
  assign beat_sel  = k_q;
  assign bus_act   = (state_q == S_FETCH);
  assign mem_we_o  = 1'b0;
  assign mem_dat_o = '0;
`endif

  assign mem_cyc_o  = bus_act;
  assign mem_adr_o  = bus_act ? (bucket_adr + AWID'({beat_sel, 4'b0})) : '0;
  assign req_rdy_o  = (state_q == S_IDLE);
  assign resp_v_o   = (state_q == S_DONE) || (state_q == S_FAULT);
  assign resp_hit_o = rhit_q;
  assign resp_err_o = rerr_q;
  assign resp_pte_o = rpte_q;
  assign resp_idx_o = ridx_q;

  always_comb begin
    state_d = state_q;
    va_d    = va_q;
    asid_d  = asid_q;
    ptbr_d  = ptbr_q;
    h_d     = h_q;
    n_d     = n_q;
    k_d     = k_q;
    mhit_d  = mhit_q;
    midx_d  = midx_q;
    mpte_d  = mpte_q;
    rhit_d  = rhit_q;
    rerr_d  = rerr_q;
    rpte_d  = rpte_q;
    ridx_d  = ridx_q;
`ifdef BW_HPTW_ABIT_UPDATE_EN
    wph_d   = wph_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          va_d    = vadr_i[61:14];
          asid_d  = asid_i;
          ptbr_d  = ptbr_i;
          h_d     = HBITS'(vadr_i[23:14] ^ asid_i);
          n_d     = '0;
          k_d     = '0;
          mhit_d  = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem_err_i) begin
          rhit_d  = 1'b0;
          rerr_d  = 1'b1;
          rpte_d  = '0;
          ridx_d  = '0;
          state_d = S_FAULT;
        end else if (mem_ack_i) begin
          if (beat_hit && !mhit_q) begin
            mhit_d = 1'b1;
            midx_d = k_q;
            mpte_d = mem_dat_i;
          end
          k_d = k_q + 3'd1;
          if (k_q == 3'd7) state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (mhit_q) begin
`ifdef BW_HPTW_ABIT_UPDATE_EN
          if (!mpte_q[17]) begin
            wph_d   = 1'b0;
            state_d = S_ABITWR;
          end else begin
            rhit_d  = 1'b1;
            rerr_d  = 1'b0;
            rpte_d  = mpte_q;
            ridx_d  = midx_q;
            state_d = S_DONE;
          end
`else
          rhit_d  = 1'b1;
          rerr_d  = 1'b0;
          rpte_d  = mpte_q;
          ridx_d  = midx_q;
          state_d = S_DONE;
`endif
        end else if (n_q < LAST_PROBE) begin
          n_d     = n_q + 4'd1;
          h_d     = h_q + 1'b1;
          k_d     = '0;
          state_d = S_FETCH;
        end else begin
          rhit_d  = 1'b0;
          rerr_d  = 1'b0;
          rpte_d  = '0;
          ridx_d  = '0;
          state_d = S_FAULT;
        end
      end
`ifdef BW_HPTW_ABIT_UPDATE_EN
      S_ABITWR: begin
        if (!wph_q) begin
          wph_d = 1'b1;
        end else if (mem_err_i) begin
          rhit_d  = 1'b0;
          rerr_d  = 1'b1;
          rpte_d  = '0;
          ridx_d  = '0;
          state_d = S_FAULT;
        end else if (mem_ack_i) begin
          rhit_d  = 1'b1;
          rerr_d  = 1'b0;
          rpte_d  = mpte_aset;
          ridx_d  = midx_q;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      va_q    <= '0;
      asid_q  <= '0;
      ptbr_q  <= '0;
      h_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      mhit_q  <= 1'b0;
      midx_q  <= '0;
      mpte_q  <= '0;
      rhit_q  <= 1'b0;
      rerr_q  <= 1'b0;
      rpte_q  <= '0;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      va_q    <= va_d;
      asid_q  <= asid_d;
      ptbr_q  <= ptbr_d;
      h_q     <= h_d;
      n_q     <= n_d;
      k_q     <= k_d;
      mhit_q  <= mhit_d;
      midx_q  <= midx_d;
      mpte_q  <= mpte_d;
      rhit_q  <= rhit_d;
      rerr_q  <= rerr_d;
      rpte_q  <= rpte_d;
      ridx_q  <= ridx_d;
    end
  end

`ifdef BW_HPTW_ABIT_UPDATE_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wph_q <= 1'b0;
    else       wph_q <= wph_d;
  end
`endif

endmodule

// File: tb/tb_bw_hpt_walker.sv
// Scoreboard bench for bw_hpt_walker: zero-wait memory model, expected responses queued per request.
module tb_bw_hpt_walker;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         req_i;
  logic         req_rdy_o;
  logic [63:0]  vadr_i;
  logic [9:0]   asid_i;
  logic [63:0]  ptbr_i;
  logic         resp_v_o, resp_hit_o, resp_err_o;
  logic [127:0] resp_pte_o;
  logic [2:0]   resp_idx_o;
  logic         mem_cyc_o, mem_we_o;
  logic [63:0]  mem_adr_o;
  logic [127:0] mem_dat_o;
  logic         mem_ack_i, mem_err_i;
  logic [127:0] mem_dat_i;

  bw_hpt_walker dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_rdy_o(req_rdy_o),
    .vadr_i(vadr_i), .asid_i(asid_i), .ptbr_i(ptbr_i),
    .resp_v_o(resp_v_o), .resp_hit_o(resp_hit_o), .resp_err_o(resp_err_o),
    .resp_pte_o(resp_pte_o), .resp_idx_o(resp_idx_o),
    .mem_cyc_o(mem_cyc_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o),
    .mem_dat_o(mem_dat_o), .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i),
    .mem_dat_i(mem_dat_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         hit;
    logic         err;
    logic [2:0]   idx;
    logic [127:0] pte;
    int           lat;
  } exp_t;

  exp_t          sb[$];
  logic [127:0]  mem[logic [63:0]];
  logic [63:0]   beat_adr[$];
  logic [63:0]   wr_adr[$];
  logic [127:0]  wr_dat[$];
  logic          err_en = 1'b0;
  logic [63:0]   err_adr = '0;
  int            cyc_cnt = 0;
  int            acc_cyc = 0;
  int            resp_seen = 0;
  int            n_chk = 0;
  int            n_fail = 0;

  // Zero-wait bus: ack/err and read data in the same cycle the address is presented.
  assign mem_err_i = mem_cyc_o && err_en && (mem_adr_o == err_adr);
  assign mem_ack_i = mem_cyc_o && !mem_err_i;
  always_comb begin
    mem_dat_i = '0;
    if (mem.exists(mem_adr_o)) mem_dat_i = mem[mem_adr_o];
  end

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (mem_cyc_o && mem_ack_i && !mem_we_o) beat_adr.push_back(mem_adr_o);
    if (mem_cyc_o && mem_ack_i && mem_we_o) begin
      wr_adr.push_back(mem_adr_o);
      wr_dat.push_back(mem_dat_o);
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_pte(input logic [63:0] va, input logic [9:0] as,
                                          input logic g, input logic a, input logic v,
                                          input logic [11:0] tag);
    logic [127:0] p;
    p          = '0;
    p[127:96]  = va[61:30];
    p[63:54]   = as;
    p[53]      = g;
    p[47:32]   = va[29:14];
    p[31]      = v;
    p[17]      = a;
    p[11:0]    = tag;
    return p;
  endfunction

  function automatic logic [9:0] hash(input logic [63:0] va, input logic [9:0] as);
    return va[23:14] ^ as;
  endfunction

  function automatic logic [63:0] bkt(input logic [63:0] pb, input logic [9:0] h);
    return pb + {47'd0, h, 7'd0};
  endfunction

  // Monitor: pops one expectation per response strobe.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (resp_v_o) begin
        resp_seen++;
        if (sb.size() == 0) chk("unexp_resp", 128'd1, 128'd0);
        else begin
          e = sb.pop_front();
          chk("resp_hit", 128'(resp_hit_o), 128'(e.hit));
          chk("resp_err", 128'(resp_err_o), 128'(e.err));
          chk("resp_pte", resp_pte_o, e.pte);
          if (e.hit) chk("resp_idx", 128'(resp_idx_o), 128'(e.idx));
          chk("latency", 128'(cyc_cnt - acc_cyc + 2), 128'(e.lat));
        end
      end
    end
  end

  task automatic push_exp(input logic hit, input logic err, input logic [2:0] idx,
                          input logic [127:0] pte, input int lat);
    exp_t e;
    e.hit = hit; e.err = err; e.idx = idx; e.pte = pte; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic do_req(input logic [63:0] va, input logic [9:0] as, input logic [63:0] pb);
    logic ok;
    @(negedge clk);
    vadr_i = va; asid_i = as; ptbr_i = pb; req_i = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (req_rdy_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept", 128'(ok), 128'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc_cnt;
    req_i   = 1'b0;
  endtask

  task automatic wait_sb();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (sb.size() != 0) begin
      chk("resp_timeout", 128'(sb.size()), 128'd0);
      sb.delete();
    end
  endtask

  initial begin
    logic [63:0]  va, pb, b;
    logic [9:0]   as, h0;
    logic [127:0] p;
    int           seen;

    rst_i = 1'b1; req_i = 1'b0; vadr_i = '0; asid_i = '0; ptbr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy",   128'(req_rdy_o), 128'd1);
    chk("rst_resp_v", 128'(resp_v_o), 128'd0);
    chk("rst_cyc",   128'(mem_cyc_o), 128'd0);
    chk("rst_we",    128'(mem_we_o),  128'd0);
    chk("rst_adr",   128'(mem_adr_o), 128'd0);
    chk("rst_pte",   resp_pte_o,      128'd0);
    @(negedge clk);
    rst_i = 1'b0;

    // Hit on probe 0, slot 3; slot 5 also matches but the lower slot wins.
    va = 64'h0000_0000_0012_C000; as = 10'd5; pb = 64'h10000;
    b  = bkt(pb, hash(va, as));
    chk("hash_bucket", 128'(b), 128'h12700);
    mem.delete();
    mem[b + 64'h00] = mk_pte(va, as, 1'b0, 1'b1, 1'b0, 12'h100);
    mem[b + 64'h10] = mk_pte(va, 10'd6, 1'b0, 1'b1, 1'b1, 12'h101);
    mem[b + 64'h20] = mk_pte(va ^ 64'h100_0000_0000, as, 1'b0, 1'b1, 1'b1, 12'h102);
    p = mk_pte(va, as, 1'b0, 1'b1, 1'b1, 12'h103);
    mem[b + 64'h30] = p;
    mem[b + 64'h50] = mk_pte(va, as, 1'b0, 1'b1, 1'b1, 12'h105);
    beat_adr.delete();
    push_exp(1'b1, 1'b0, 3'd3, p, 11);
    do_req(va, as, pb);
    #1;
    chk("busy_rdy", 128'(req_rdy_o), 128'd0);
    wait_sb();
    chk("p0_beats", 128'(beat_adr.size()), 128'd8);
    if (beat_adr.size() == 8) begin
      chk("p0_adr0", 128'(beat_adr[0]), 128'h12700);
      chk("p0_adr7", 128'(beat_adr[7]), 128'h12770);
    end
    @(posedge clk);
    #1;
    chk("hold_v",   128'(resp_v_o),   128'd0);
    chk("hold_idx", 128'(resp_idx_o), 128'd3);

    // Global entry with another ASID, then the same entry non-global -> not found.
    va = 64'h0000_0123_4567_8000; as = 10'd5; pb = 64'h80000;
    h0 = hash(va, as);
    mem.delete();
    p = mk_pte(va, 10'd7, 1'b1, 1'b1, 1'b1, 12'h200);
    mem[bkt(pb, h0)] = p;
    push_exp(1'b1, 1'b0, 3'd0, p, 11);
    do_req(va, as, pb);
    wait_sb();
    mem[bkt(pb, h0)] = mk_pte(va, 10'd7, 1'b0, 1'b1, 1'b1, 12'h201);
    beat_adr.delete();
    push_exp(1'b0, 1'b0, 3'd0, 128'd0, 38);
    do_req(va, as, pb);
    wait_sb();
    chk("nf_beats", 128'(beat_adr.size()), 128'd32);
    if (beat_adr.size() == 32)
      chk("nf_adr_last", 128'(beat_adr[31]), 128'(bkt(pb, h0 + 10'd3) + 64'h70));

    // Probe wrap: h0 = 0x3FF, match in bucket 0x001 slot 6.
    va = 64'h0000_0000_00FF_C000; as = 10'd0; pb = 64'h40000;
    mem.delete();
    p = mk_pte(va, as, 1'b0, 1'b1, 1'b1, 12'h300);
    mem[pb + 64'h80 + 64'h60] = p;
    beat_adr.delete();
    push_exp(1'b1, 1'b0, 3'd6, p, 29);
    do_req(va, as, pb);
    wait_sb();
    chk("wrap_beats", 128'(beat_adr.size()), 128'd24);
    if (beat_adr.size() == 24) begin
      chk("wrap_b0",  128'(beat_adr[0]),  128'(pb + 64'h1FF80));
      chk("wrap_b8",  128'(beat_adr[8]),  128'(pb));
      chk("wrap_b16", 128'(beat_adr[16]), 128'(pb + 64'h80));
    end

    // Bus error on beat 5 of probe 1.
    va = 64'h0000_0005_0000_4000; as = 10'd3; pb = 64'hC0000;
    mem.delete();
    err_adr = bkt(pb, hash(va, as) + 10'd1) + 64'h50;
    err_en  = 1'b1;
    beat_adr.delete();
    push_exp(1'b0, 1'b1, 3'd0, 128'd0, 17);
    do_req(va, as, pb);
    wait_sb();
    chk("err_cyc", 128'(mem_cyc_o), 128'd0);
    chk("err_beats", 128'(beat_adr.size()), 128'd13);
    err_en = 1'b0;

`ifdef BW_HPTW_ABIT_UPDATE_EN
    // Accessed bit clear -> write-back with a=1, response carries a=1.
    va = 64'h0000_0000_0034_8000; as = 10'd9; pb = 64'h20000;
    b  = bkt(pb, hash(va, as));
    mem.delete();
    p = mk_pte(va, as, 1'b0, 1'b0, 1'b1, 12'h400);
    mem[b + 64'h20] = p;
    p[17] = 1'b1;
    wr_adr.delete(); wr_dat.delete();
    push_exp(1'b1, 1'b0, 3'd2, p, 13);
    do_req(va, as, pb);
    wait_sb();
    chk("abit_wr_cnt", 128'(wr_adr.size()), 128'd1);
    if (wr_adr.size() == 1) begin
      chk("abit_wr_adr", 128'(wr_adr[0]), 128'(b + 64'h20));
      chk("abit_wr_dat", wr_dat[0], p);
    end
`endif

    // Reset mid-FETCH: bus released at once, no response.
    va = 64'h0000_0000_0012_C000; as = 10'd5; pb = 64'h10000;
    b  = bkt(pb, hash(va, as));
    mem.delete();
    p = mk_pte(va, as, 1'b0, 1'b1, 1'b1, 12'h500);
    mem[b + 64'h30] = p;
    do_req(va, as, pb);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_cyc", 128'(mem_cyc_o), 128'd1);
    seen  = resp_seen;
    rst_i = 1'b1;
    #1;
    chk("rst_mid_cyc", 128'(mem_cyc_o), 128'd0);
    chk("rst_mid_rdy", 128'(req_rdy_o), 128'd1);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_no_resp", 128'(resp_seen - seen), 128'd0);

    // Walker recovers and serves the next request normally.
    push_exp(1'b1, 1'b0, 3'd3, p, 11);
    do_req(va, as, pb);
    wait_sb();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", n_chk, 0);
    $fatal(1, "timeout");
  end

endmodule
